// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared widths, sprite geometry and loader state encoding
package sprite_pkg;

  localparam int PIX_W       = 24;
  localparam int COORD_W     = 10;
  localparam int SPRITE_SIDE = 8;
  localparam int SPRITE_PIX  = SPRITE_SIDE * SPRITE_SIDE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BLANK,
    ST_SETXY,
    ST_STREAM,
    ST_SHAPE,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/sprite_loader.sv
// rtl/sprite_loader.sv - sequences setxy, 64 raster pixel writes and setshape into one sprite object
module sprite_loader #(
  parameter int PIX_W       = 24,
  parameter int COORD_W     = 10,
  parameter int WAIT_VBLANK = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [63:0]        cmd_shape,
  input  logic               vblank,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIX_W-1:0]   pix_data,
  output logic [COORD_W-1:0] new_x,
  output logic [COORD_W-1:0] new_y,
  output logic [63:0]        new_shape,
  output logic               setxy,
  output logic               change_pxl,
  output logic [PIX_W-1:0]   pxl_out,
  output logic               setshape,
  output logic               obj_active,
  output logic               busy,
  output logic               done
);

  import sprite_pkg::*;

  localparam logic [5:0] LAST_IDX = 6'(SPRITE_PIX - 1);

  loader_state_t      state;
  loader_state_t      state_d;
  logic [COORD_W-1:0] base_x;
  logic [COORD_W-1:0] base_y;
  logic [63:0]        shape_q;
  logic [5:0]         idx;
  logic               active_q;
  logic               accept;
  logic               beat;

  assign accept = cmd_valid && (state == ST_IDLE);
  assign beat   = pix_valid && (state == ST_STREAM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      base_x   <= '0;
      base_y   <= '0;
      shape_q  <= '0;
      idx      <= '0;
      active_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        base_x  <= cmd_x;
        base_y  <= cmd_y;
        shape_q <= cmd_shape;
        idx     <= '0;
      end else if (beat) begin
        idx <= idx + 6'd1;
      end
      // Registered so the object sees active low during the SETXY cycle itself
      if (state_d == ST_SETXY) begin
        active_q <= 1'b0;
      end else if (state == ST_SHAPE) begin
        active_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state;
    cmd_ready  = 1'b0;
    setxy      = 1'b0;
    change_pxl = 1'b0;
    pix_ready  = 1'b0;
    setshape   = 1'b0;
    done       = 1'b0;
    pxl_out    = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_WAIT_BLANK;
      end
      ST_WAIT_BLANK: begin
        if (vblank || (WAIT_VBLANK == 0)) state_d = ST_SETXY;
      end
      ST_SETXY: begin
        setxy   = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        pix_ready  = 1'b1;
        change_pxl = pix_valid;
        pxl_out    = pix_data;
        if (pix_valid && (idx == LAST_IDX)) state_d = ST_SHAPE;
      end
      ST_SHAPE: begin
        setshape = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // idx is 0 during SETXY, so the same adders serve both setxy and change_pxl
  assign new_x      = base_x + COORD_W'(idx[2:0]);
  assign new_y      = base_y + COORD_W'(idx[5:3]);
  assign new_shape  = shape_q;
  assign obj_active = active_q;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_sprite_loader.sv
// tb/tb_sprite_loader.sv - directed self-checking bench for sprite_loader
module tb_sprite_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [9:0]  cmd_y;
  logic [63:0] cmd_shape;
  logic        vblank;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic [9:0]  new_x;
  logic [9:0]  new_y;
  logic [63:0] new_shape;
  logic        setxy;
  logic        change_pxl;
  logic [23:0] pxl_out;
  logic        setshape;
  logic        obj_active;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  int          setxy_cyc, setxy2_cyc, shape_cyc, done_cyc, ready_cyc;
  int          wr_first, wr_last, wr_cnt, mirror_bad, onehot_bad, busy_bad;
  logic        t_ready;
  logic [9:0]  sx, sy;
  logic [9:0]  wr_x [64];
  logic [9:0]  wr_y [64];
  logic [23:0] wr_d [64];
  logic [63:0] shape_val;
  logic        act [256];

  sprite_loader #(.PIX_W(24), .COORD_W(10), .WAIT_VBLANK(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_shape(cmd_shape), .vblank(vblank),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .new_x(new_x), .new_y(new_y), .new_shape(new_shape), .setxy(setxy),
    .change_pxl(change_pxl), .pxl_out(pxl_out), .setshape(setshape),
    .obj_active(obj_active), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Issues one command and records what the object interface sees for ncyc cycles after acceptance
  task automatic run_load(input logic [9:0] x, input logic [9:0] y, input logic [63:0] shp,
                          input int vb_delay, input bit stall, input bit hold_next,
                          input logic [9:0] x2, input logic [9:0] y2, input int ncyc);
    int p;
    p = 0;
    setxy_cyc = 0; setxy2_cyc = 0; shape_cyc = 0; done_cyc = 0; ready_cyc = 0;
    wr_first = 0; wr_last = 0; wr_cnt = 0; mirror_bad = 0; onehot_bad = 0; busy_bad = 0;
    sx = '0; sy = '0; shape_val = '0;
    for (int i = 0; i < 256; i++) act[i] = 1'bx;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_shape = shp;
    vblank = (vb_delay == 0); pix_valid = 1'b0; pix_data = '0;
    @(negedge clk);
    t_ready = cmd_ready;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      cmd_valid = hold_next; cmd_x = x2; cmd_y = y2;
      vblank    = (vb_delay == 0) ? 1'b1 : ((c >= vb_delay) && (c < vb_delay + 2));
      pix_valid = stall ? ((c % 3) == 0) : 1'b1;
      pix_data  = 24'(p) * 24'h010101;
      @(negedge clk);
      act[c] = obj_active;
      if (setxy) begin
        if (setxy_cyc == 0) begin setxy_cyc = c; sx = new_x; sy = new_y; end
        else if (setxy2_cyc == 0) setxy2_cyc = c;
      end
      if (setxy_cyc == 0 && !busy) busy_bad++;
      if (pix_ready && (change_pxl !== pix_valid)) mirror_bad++;
      if (!pix_ready && change_pxl) mirror_bad++;
      if (int'(setxy) + int'(change_pxl) + int'(setshape) > 1) onehot_bad++;
      if (change_pxl) begin
        if (wr_cnt == 0) wr_first = c;
        wr_last = c;
        if (wr_cnt < 64) begin wr_x[wr_cnt] = new_x; wr_y[wr_cnt] = new_y; wr_d[wr_cnt] = pxl_out; end
        wr_cnt++;
      end
      if (setshape && shape_cyc == 0) begin shape_cyc = c; shape_val = new_shape; end
      if (done && done_cyc == 0) done_cyc = c;
      if (cmd_ready && ready_cyc == 0) ready_cyc = c;
      if (pix_ready && pix_valid) p++;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++; if ({busy, done, setxy, change_pxl, setshape, pix_ready, obj_active} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000000", {busy, done, setxy, change_pxl, setshape, pix_ready, obj_active}); end
    n_checks++; if ({new_x, new_y, new_shape, pxl_out} !== '0) begin
      n_fail++; $display("FAIL reset_buses: got x=%0d y=%0d shape=%h pxl=%h expected all 0", new_x, new_y, new_shape, pxl_out); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_load;
    run_load(10'd100, 10'd50, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 1'b0, 10'd0, 10'd0, 72);
    n_checks++; if (t_ready !== 1'b1) begin n_fail++; $display("FAIL basic_accept_ready: got %b expected 1", t_ready); end
    n_checks++; if (setxy_cyc !== 2) begin n_fail++; $display("FAIL basic_setxy_cycle: got %0d expected 2", setxy_cyc); end
    n_checks++; if ({sx, sy} !== {10'd100, 10'd50}) begin n_fail++; $display("FAIL basic_setxy_xy: got (%0d,%0d) expected (100,50)", sx, sy); end
    n_checks++; if (act[2] !== 1'b0) begin n_fail++; $display("FAIL basic_active_at_setxy: got %b expected 0", act[2]); end
    n_checks++; if (wr_cnt !== 64) begin n_fail++; $display("FAIL basic_write_count: got %0d expected 64", wr_cnt); end
    n_checks++; if ({wr_first, wr_last} !== {32'd3, 32'd66}) begin n_fail++; $display("FAIL basic_write_window: got %0d..%0d expected 3..66", wr_first, wr_last); end
    n_checks++; if ({wr_x[0], wr_y[0], wr_d[0]} !== {10'd100, 10'd50, 24'h000000}) begin
      n_fail++; $display("FAIL basic_first_write: got (%0d,%0d,%h) expected (100,50,000000)", wr_x[0], wr_y[0], wr_d[0]); end
    n_checks++; if ({wr_x[63], wr_y[63], wr_d[63]} !== {10'd107, 10'd57, 24'h3F3F3F}) begin
      n_fail++; $display("FAIL basic_last_write: got (%0d,%0d,%h) expected (107,57,3f3f3f)", wr_x[63], wr_y[63], wr_d[63]); end
    n_checks++; if (shape_cyc !== 67) begin n_fail++; $display("FAIL basic_shape_cycle: got %0d expected 67", shape_cyc); end
    n_checks++; if (shape_val !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL basic_shape_value: got %h expected ffffffffffffffff", shape_val); end
    n_checks++; if (done_cyc !== 68) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 68", done_cyc); end
    n_checks++; if (ready_cyc !== 69) begin n_fail++; $display("FAIL basic_ready_cycle: got %0d expected 69", ready_cyc); end
    n_checks++; if (act[69] !== 1'b1) begin n_fail++; $display("FAIL basic_active_after_done: got %b expected 1", act[69]); end
    n_checks++; if ({mirror_bad, onehot_bad} !== 64'd0) begin n_fail++; $display("FAIL basic_strobes: got mirror=%0d onehot=%0d expected 0 0", mirror_bad, onehot_bad); end
  endtask

  task automatic test_reset_clears_active;
    @(negedge clk);
    n_checks++; if (obj_active !== 1'b1) begin n_fail++; $display("FAIL hold_active_idle: got %b expected 1", obj_active); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (obj_active !== 1'b0) begin n_fail++; $display("FAIL reset_clears_active: got %b expected 0", obj_active); end
  endtask

  task automatic test_vblank_gating;
    run_load(10'd200, 10'd100, 64'h0123_4567_89AB_CDEF, 20, 1'b0, 1'b0, 10'd0, 10'd0, 100);
    n_checks++; if (setxy_cyc !== 21) begin n_fail++; $display("FAIL vblank_setxy_cycle: got %0d expected 21", setxy_cyc); end
    n_checks++; if (busy_bad !== 0) begin n_fail++; $display("FAIL vblank_busy_while_waiting: got %0d idle cycles expected 0", busy_bad); end
    n_checks++; if (wr_cnt !== 64) begin n_fail++; $display("FAIL vblank_write_count: got %0d expected 64", wr_cnt); end
    n_checks++; if (done_cyc !== 87) begin n_fail++; $display("FAIL vblank_done_cycle: got %0d expected 87", done_cyc); end
  endtask

  task automatic test_stream_stalls;
    int coord_bad;
    coord_bad = 0;
    run_load(10'd10, 10'd20, 64'h8142_2418_1824_4281, 0, 1'b1, 1'b0, 10'd0, 10'd0, 220);
    for (int i = 0; i < 64; i++)
      if ({wr_x[i], wr_y[i], wr_d[i]} !== {10'(10 + i % 8), 10'(20 + i / 8), 24'(i) * 24'h010101}) coord_bad++;
    n_checks++; if (wr_cnt !== 64) begin n_fail++; $display("FAIL stall_write_count: got %0d expected 64", wr_cnt); end
    n_checks++; if (mirror_bad !== 0) begin n_fail++; $display("FAIL stall_change_mirrors_valid: got %0d bad cycles expected 0", mirror_bad); end
    n_checks++; if (coord_bad !== 0) begin n_fail++; $display("FAIL stall_raster_order: got %0d bad writes expected 0", coord_bad); end
    n_checks++; if (shape_val !== 64'h8142_2418_1824_4281) begin n_fail++; $display("FAIL stall_shape_value: got %h expected 8142241818244281", shape_val); end
    n_checks++; if (onehot_bad !== 0) begin n_fail++; $display("FAIL stall_onehot: got %0d bad cycles expected 0", onehot_bad); end
  endtask

  task automatic test_wrap;
    run_load(10'd1020, 10'd1022, 64'h0000_0000_0000_0001, 0, 1'b0, 1'b0, 10'd0, 10'd0, 72);
    n_checks++; if ({wr_x[0], wr_y[0]} !== {10'd1020, 10'd1022}) begin n_fail++; $display("FAIL wrap_idx0: got (%0d,%0d) expected (1020,1022)", wr_x[0], wr_y[0]); end
    n_checks++; if ({wr_x[7], wr_y[7]} !== {10'd3, 10'd1022}) begin n_fail++; $display("FAIL wrap_idx7: got (%0d,%0d) expected (3,1022)", wr_x[7], wr_y[7]); end
    n_checks++; if ({wr_x[63], wr_y[63]} !== {10'd3, 10'd5}) begin n_fail++; $display("FAIL wrap_idx63: got (%0d,%0d) expected (3,5)", wr_x[63], wr_y[63]); end
  endtask

  task automatic test_back_to_back;
    run_load(10'd100, 10'd50, 64'hFFFF_0000_FFFF_0000, 0, 1'b0, 1'b1, 10'd200, 10'd300, 75);
    n_checks++; if (ready_cyc !== 69) begin n_fail++; $display("FAIL b2b_second_accept: got %0d expected 69", ready_cyc); end
    n_checks++; if (setxy2_cyc !== 71) begin n_fail++; $display("FAIL b2b_second_setxy: got %0d expected 71", setxy2_cyc); end
    n_checks++; if ({act[70], act[71]} !== 2'b10) begin n_fail++; $display("FAIL b2b_active_drop: got %b%b expected 10", act[70], act[71]); end
  endtask

  task automatic test_reset_mid;
    int n;
    int p;
    int late;
    n = 0; p = 0; late = 0;
    @(posedge clk); #1; rst = 1'b1; cmd_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    cmd_valid = 1'b1; cmd_x = 10'd300; cmd_y = 10'd200; cmd_shape = 64'hAAAA_5555_AAAA_5555;
    vblank = 1'b1; pix_valid = 1'b1; pix_data = '0;
    @(posedge clk); #1; cmd_valid = 1'b0;
    for (int c = 0; c < 100 && n < 30; c++) begin
      pix_data = 24'(p) * 24'h010101;
      @(negedge clk);
      if (change_pxl) n++;
      if (pix_ready && pix_valid) p++;
      @(posedge clk); #1;
    end
    n_checks++; if (n !== 30) begin n_fail++; $display("FAIL rstmid_reach_idx30: got %0d writes expected 30", n); end
    rst = 1'b1; pix_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0; pix_valid = 1'b1;
    @(negedge clk);
    n_checks++; if ({cmd_ready, busy, obj_active, change_pxl} !== 4'b1000) begin
      n_fail++; $display("FAIL rstmid_idle_after: got ready/busy/active/change=%b expected 1000", {cmd_ready, busy, obj_active, change_pxl}); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (change_pxl || pix_ready) late++;
    end
    n_checks++; if (late !== 0) begin n_fail++; $display("FAIL rstmid_no_more_writes: got %0d cycles expected 0", late); end
    run_load(10'd300, 10'd200, 64'hAAAA_5555_AAAA_5555, 0, 1'b0, 1'b0, 10'd0, 10'd0, 72);
    n_checks++; if ({wr_x[0], wr_y[0], wr_d[0]} !== {10'd300, 10'd200, 24'h000000}) begin
      n_fail++; $display("FAIL rstmid_restart_idx0: got (%0d,%0d,%h) expected (300,200,000000)", wr_x[0], wr_y[0], wr_d[0]); end
    n_checks++; if (wr_cnt !== 64) begin n_fail++; $display("FAIL rstmid_restart_count: got %0d expected 64", wr_cnt); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_shape = '0;
    vblank = 1'b0; pix_valid = 1'b0; pix_data = '0;
    test_reset;
    test_basic_load;
    test_reset_clears_active;
    test_vblank_gating;
    test_stream_stalls;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
